// File: rtl/esc_pwm_generator.sv
// esc_pwm_generator
//   Four-channel ESC PWM generator. A period counter advances once per rising
//   edge of tick_clk and wraps after PERIOD_TICKS ticks. Duty writes land in
//   per-channel shadow registers. All shadows are copied into the active
//   registers together at the period wrap, so an output never sees a
//   half-updated period. A DISARMED/ARMING/RUN FSM keeps the outputs low until
//   one full period has been counted after arming.
//
// Ports
//   clk          system clock, rising edge
//   resetn       synchronous, active-low reset
//   tick_clk     divided clock (already in the clk domain)
//   arm          level: 1 requests motor output, 0 forces outputs low
//   duty_valid   duty write request
//   duty_ready   duty write accept (low only in the wrap clock)
//   duty_ch      target channel 0..3
//   duty_val     requested high time in ticks
//   pwm_out      registered per-channel PWM
//   period_start one-clock pulse after each period boundary in RUN
module esc_pwm_generator #(
  parameter int unsigned PERIOD_TICKS = 250,
  parameter int unsigned DUTY_W       = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tick_clk,
  input  logic              arm,
  input  logic              duty_valid,
  output logic              duty_ready,
  input  logic [1:0]        duty_ch,
  input  logic [DUTY_W-1:0] duty_val,
  output logic [3:0]        pwm_out,
  output logic              period_start
);

  typedef enum logic [1:0] {
    DISARMED,
    ARMING,
    RUN
  } state_t;

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD_TICKS - 1);

  state_t                   state_q, state_d;
  logic [DUTY_W-1:0]        cnt_q, cnt_d;
  logic                     tick_q;
  logic [3:0][DUTY_W-1:0]   shadow_q, shadow_d;
  logic [3:0][DUTY_W-1:0]   active_q, active_d;
  logic [3:0]               pwm_q, pwm_d;
  logic                     ps_q, ps_d;

  logic tick;
  logic wrap;

  assign tick = tick_clk & ~tick_q;
  assign wrap = tick & (cnt_q == CNT_LAST);

  // Refusing writes in the wrap clock keeps the shadow stable while it is
  // copied into the active set.
  assign duty_ready = ~wrap | ~resetn;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    ps_d     = 1'b0;

    // A duty >= PERIOD_TICKS saturates high because cnt never reaches it.
    for (int unsigned i = 0; i < 4; i++) begin
      pwm_d[i] = (state_q == RUN) && (cnt_q < active_q[i]);
    end

    if (duty_valid && duty_ready) begin
      shadow_d[duty_ch] = duty_val;
    end

    // arm low wins over a coincident wrap: no active copy, no period_start.
    if (!arm) begin
      state_d  = DISARMED;
      cnt_d    = '0;
      active_d = '0;
    end else begin
      case (state_q)
        DISARMED: begin
          cnt_d    = '0;
          active_d = '0;
          state_d  = ARMING;
        end
        ARMING, RUN: begin
          if (wrap) begin
            cnt_d    = '0;
            active_d = shadow_q;
            state_d  = RUN;
            ps_d     = 1'b1;
          end else if (tick) begin
            cnt_d = cnt_q + DUTY_W'(1);
          end
        end
        default: begin
          state_d = DISARMED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= DISARMED;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= '0;
      ps_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_clk;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      ps_q     <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule

// File: doc/esc_pwm_generator.md
ESC_PWM_GENERATOR -- requirements
Module: esc_pwm_generator

Interface
REQ-001 SHALL have parameter PERIOD_TICKS, default 250: PWM period in tick_clk rising edges; legal range 2..256.
REQ-002 SHALL have parameter DUTY_W, default 8: width of duty values and of the period counter.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port tick_clk, input, 1: divided clock from the upstream clock divider, registered in the clk domain, so no synchronizer.
REQ-006 SHALL have port arm, input, 1: level; 1 requests motor output, 0 forces outputs low.
REQ-007 SHALL have port duty_valid, input, 1: duty write request.
REQ-008 SHALL have port duty_ready, output, 1: duty write accept.
REQ-009 SHALL have port duty_ch, input, 2: target channel 0..3.
REQ-010 SHALL have port duty_val, input, DUTY_W: requested high time in ticks.
REQ-011 SHALL have port pwm_out, output, 4: per-channel PWM, registered.
REQ-012 SHALL have port period_start, output, 1: one-clk pulse at each period boundary in RUN.

Function
REQ-013 SHALL derive tick = tick_clk & ~tick_q, where tick_q is tick_clk delayed one clk; tick is high at most one clk per tick_clk rising edge.
REQ-014 SHALL hold a period counter cnt that increments on tick and wraps from PERIOD_TICKS-1 to 0; wrap = tick && cnt == PERIOD_TICKS-1.
REQ-015 SHALL keep per-channel shadow[3:0] and active[3:0] duty registers.
REQ-016 SHALL transfer a duty write when duty_valid && duty_ready, storing duty_val into shadow[duty_ch] at that clk edge.
REQ-017 SHALL drive duty_ready = 1 except in the clk where wrap is high; a write is not accepted in that clk, and the master holds valid/ch/val until accepted.
REQ-018 SHALL copy all shadow into active on wrap, giving glitch-free, period-aligned updates; a write accepted in any clk of a period takes effect at the next wrap.
REQ-019 SHALL saturate duty: an active value >= PERIOD_TICKS gives constant high in RUN; 0 gives constant low.
REQ-020 SHALL use FSM states DISARMED, ARMING and RUN.
REQ-021 DISARMED SHALL hold cnt = 0 and active = 0, and go to ARMING when arm = 1.
REQ-022 ARMING SHALL count normally with pwm_out = 0, and go to RUN on the first wrap (active loaded on that same wrap).
REQ-023 RUN SHALL remain while arm = 1.
REQ-024 SHALL go from any state to DISARMED on the next clk when arm = 0, with cnt cleared; shadow values are retained.
REQ-025 SHALL register pwm_out: pwm_out[i](t+1) = (state(t) == RUN) && (cnt(t) < active[i](t)).
REQ-026 SHALL assert period_start for one clk: the clk after a wrap that occurs while in RUN or causes ARMING->RUN.
REQ-027 SHALL treat simultaneous arm fall and wrap as disarm: no active copy, no period_start.

Reset
REQ-028 SHALL, while resetn = 0 at a clk edge, set state = DISARMED, cnt = 0, tick_q = 0, shadow = 0, active = 0, pwm_out = 0, period_start = 0, duty_ready = 1.
REQ-029 SHALL take reset with priority over arm, tick and duty writes; reset mid-period discards all duty state.

Verification (PERIOD_TICKS=10; tick_clk toggles every 2 clk, so 1 tick per 4 clk)
REQ-030 Bench SHALL cover reset: hold resetn = 0 for 3 clk with arm = 1 and tick_clk toggling -> pwm_out = 0, period_start = 0, duty_ready = 1 throughout.
REQ-031 Bench SHALL cover basic PWM: write ch0 = 3, ch1 = 0, ch2 = 10, ch3 = 255, then arm = 1 -> after the ARMING period, each 40-clk period has pwm_out[0] high 12 clk, [1] never, [2] and [3] always; period_start pulses every 40 clk.
REQ-032 Bench SHALL cover mid-period update: in RUN, write ch0 = 7 at cnt = 4 -> the current period still shows duty 3; the next period shows high 28 clk.
REQ-033 Bench SHALL cover the wrap collision: hold duty_valid = 1 across a wrap -> duty_ready = 0 for exactly that clk; the write is accepted the next clk and applies one period later.
REQ-034 Bench SHALL cover disarm: drop arm at cnt = 5 in RUN -> pwm_out = 0 within 2 clk; re-arm -> one full ARMING period low, then the prior shadow duties resume.
REQ-035 Bench SHALL cover tick edge detect: hold tick_clk = 1 for 20 clk -> cnt advances exactly once.
